// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready command in, one SETUP+ACCESS transfer to FC/CONV/POOL, one response out.
// Optional ACCESS-phase timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                CMD_VALID,
   output logic                CMD_READY,
   input  logic                CMD_WRITE,
   input  logic [1:0]          CMD_SEL,
   input  logic [ADDR_W-1:0]   CMD_ADDR,
   input  logic [DATA_W-1:0]   CMD_WDATA,
   output logic                RSP_VALID,
   input  logic                RSP_READY,
   output logic [DATA_W-1:0]   RSP_RDATA,
   output logic                RSP_ERR,
   output logic                RSP_TIMEOUT,
   output logic [ADDR_W-1:0]   PADDR,
   output logic                PWRITE,
   output logic [DATA_W-1:0]   PWDATA,
   output logic                PENABLE,
   output logic [2:0]          PSEL,
   input  logic [2:0]          PREADY,
   input  logic [3*DATA_W-1:0] PRDATA,
   input  logic [2:0]          PSLVERR,
   output logic                BUSY
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]        state;
   logic [1:0]        sel_q;
   logic              pready_sel;
   logic              pslverr_sel;
   logic [DATA_W-1:0] prdata_sel;
   logic              timeout_hit;
   logic              access_done;

   // Only the addressed slave's return signals are ever looked at.
   always_comb begin
      pready_sel  = 1'b0;
      pslverr_sel = 1'b0;
      prdata_sel  = '0;
      case (sel_q)
         2'd0: begin
            pready_sel  = PREADY[0];
            pslverr_sel = PSLVERR[0];
            prdata_sel  = PRDATA[0*DATA_W +: DATA_W];
         end
         2'd1: begin
            pready_sel  = PREADY[1];
            pslverr_sel = PSLVERR[1];
            prdata_sel  = PRDATA[1*DATA_W +: DATA_W];
         end
         2'd2: begin
            pready_sel  = PREADY[2];
            pslverr_sel = PSLVERR[2];
            prdata_sel  = PRDATA[2*DATA_W +: DATA_W];
         end
         default: ;
      endcase
   end

   assign access_done = (state == S_ACCESS) && (pready_sel || timeout_hit);
   assign CMD_READY   = (state == S_IDLE);
   assign BUSY        = (state != S_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
   logic [15:0] wait_cnt;
   logic        rsp_timeout_q;

   assign timeout_hit = (state == S_ACCESS) && !pready_sel &&
                        (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign RSP_TIMEOUT = rsp_timeout_q;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wait_cnt      <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         if (state == S_SETUP)
            wait_cnt <= '0;
         else if (state == S_ACCESS && !pready_sel)
            wait_cnt <= wait_cnt + 16'd1;
         if (state == S_IDLE && CMD_VALID)
            rsp_timeout_q <= 1'b0;
         else if (access_done)
            rsp_timeout_q <= timeout_hit;
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
   assign timeout_hit        = 1'b0;
   assign RSP_TIMEOUT        = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_IDLE;
         sel_q     <= 2'd0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         PSEL      <= 3'b000;
         PENABLE   <= 1'b0;
         RSP_VALID <= 1'b0;
         RSP_RDATA <= '0;
         RSP_ERR   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (CMD_VALID) begin
                  sel_q  <= CMD_SEL;
                  PADDR  <= CMD_ADDR;
                  PWRITE <= CMD_WRITE;
                  PWDATA <= CMD_WDATA;
                  if (CMD_SEL == 2'd3) begin
                     state     <= S_RESP;
                     RSP_VALID <= 1'b1;
                     RSP_ERR   <= 1'b1;
                     RSP_RDATA <= '0;
                  end else begin
                     state <= S_SETUP;
                     PSEL  <= 3'b001 << CMD_SEL;
                  end
               end
            end
            S_SETUP: begin
               state   <= S_ACCESS;
               PENABLE <= 1'b1;
            end
            S_ACCESS: begin
               if (access_done) begin
                  state     <= S_RESP;
                  PSEL      <= 3'b000;
                  PENABLE   <= 1'b0;
                  RSP_VALID <= 1'b1;
                  RSP_ERR   <= pslverr_sel | timeout_hit;
                  // Read data is only meaningful for a clean, completed read.
                  RSP_RDATA <= (PWRITE || pslverr_sel || timeout_hit) ? '0 : prdata_sel;
               end
            end
            default: begin
               if (RSP_READY) begin
                  state     <= S_IDLE;
                  RSP_VALID <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master; the timeout scenario runs only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_cmd_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [1:0]  cmd_sel;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr, pwdata;
   logic        pwrite, penable, busy;
   logic [2:0]  psel, pready, pslverr;
   logic [95:0] prdata;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
      .CLK(clk), .RESET(rst),
      .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
      .CMD_SEL(cmd_sel), .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata),
      .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_RDATA(rsp_rdata),
      .RSP_ERR(rsp_err), .RSP_TIMEOUT(rsp_timeout),
      .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata), .PENABLE(penable),
      .PSEL(psel), .PREADY(pready), .PRDATA(prdata), .PSLVERR(pslverr),
      .BUSY(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
   endtask

   task automatic send(input logic wr, input logic [1:0] sel,
                       input logic [31:0] addr, input logic [31:0] wd);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_sel   = sel;
      cmd_addr  = addr;
      cmd_wdata = wd;
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = 2'd0;
      cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b1;
      pready = 3'b111; pslverr = 3'b000; prdata = '0;
      tick(); tick();
      rst = 1'b0;
      chk1("rst_cmd_ready", cmd_ready, 1'b1);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      chk ("rst_psel", 32'(psel), 32'h0);
      chk1("rst_penable", penable, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk ("rst_paddr", paddr, 32'h0);
      chk1("rst_timeout", rsp_timeout, 1'b0);

      // 1: zero-wait write to FC
      send(1'b1, 2'd0, 32'h10, 32'hA5A5_0001);
      tick();
      cmd_valid = 1'b0;
      chk ("w_setup_psel", 32'(psel), 32'h1);
      chk1("w_setup_penable", penable, 1'b0);
      chk ("w_setup_paddr", paddr, 32'h10);
      tick();
      chk ("w_access_psel", 32'(psel), 32'h1);
      chk1("w_access_penable", penable, 1'b1);
      chk ("w_access_pwdata", pwdata, 32'hA5A5_0001);
      chk1("w_access_pwrite", pwrite, 1'b1);
      chk1("w_access_rsp_valid", rsp_valid, 1'b0);
      tick();
      chk1("w_rsp_valid", rsp_valid, 1'b1);
      chk1("w_rsp_err", rsp_err, 1'b0);
      chk ("w_rsp_rdata", rsp_rdata, 32'h0);
      chk ("w_rsp_psel", 32'(psel), 32'h0);
      chk1("w_rsp_penable", penable, 1'b0);
      chk1("w_rsp_cmd_ready", cmd_ready, 1'b0);
      tick();
      chk1("w_idle_rsp_valid", rsp_valid, 1'b0);
      chk1("w_idle_cmd_ready", cmd_ready, 1'b1);

      // 2: CONV read with 3 wait states; FC error/data must be ignored
      pready  = 3'b101;
      pslverr = 3'b001;
      prdata  = {32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
      send(1'b0, 2'd1, 32'h04, 32'h0);
      tick();
      cmd_valid = 1'b0;
      chk ("r_setup_psel", 32'(psel), 32'h2);
      tick();
      for (int i = 2; i <= 4; i++) begin
         chk1("r_wait_rsp_valid", rsp_valid, 1'b0);
         chk1("r_wait_penable", penable, 1'b1);
         tick();
      end
      chk1("r_c5_rsp_valid", rsp_valid, 1'b0);
      chk ("r_c5_paddr", paddr, 32'h04);
      pready = 3'b111;
      tick();
      chk1("r_rsp_valid", rsp_valid, 1'b1);
      chk ("r_rsp_rdata", rsp_rdata, 32'h1234_5678);
      chk1("r_rsp_err", rsp_err, 1'b0);
      tick();
      pslverr = 3'b000;

      // 3: POOL read with slave error, response held off for 4 cycles
      pslverr   = 3'b100;
      rsp_ready = 1'b0;
      send(1'b0, 2'd2, 32'h08, 32'h0);
      tick();
      send(1'b0, 2'd3, 32'h0C, 32'h0);
      chk ("e_setup_psel", 32'(psel), 32'h4);
      tick();
      tick();
      for (int i = 0; i < 4; i++) begin
         chk1("e_hold_rsp_valid", rsp_valid, 1'b1);
         chk1("e_hold_rsp_err", rsp_err, 1'b1);
         chk ("e_hold_rsp_rdata", rsp_rdata, 32'h0);
         chk1("e_hold_cmd_ready", cmd_ready, 1'b0);
         chk ("e_hold_psel", 32'(psel), 32'h0);
         tick();
      end
      pslverr   = 3'b000;
      rsp_ready = 1'b1;
      chk1("e_last_rsp_valid", rsp_valid, 1'b1);
      tick();
      chk1("e_done_rsp_valid", rsp_valid, 1'b0);
      chk1("e_done_cmd_ready", cmd_ready, 1'b1);

      // 4: invalid select, issued back to back
      tick();
      chk1("inv1_rsp_valid", rsp_valid, 1'b1);
      chk1("inv1_rsp_err", rsp_err, 1'b1);
      chk ("inv1_psel", 32'(psel), 32'h0);
      chk1("inv1_busy", busy, 1'b1);
      tick();
      chk1("inv_gap_rsp_valid", rsp_valid, 1'b0);
      chk1("inv_gap_cmd_ready", cmd_ready, 1'b1);
      tick();
      cmd_valid = 1'b0;
      chk1("inv2_rsp_valid", rsp_valid, 1'b1);
      chk1("inv2_rsp_err", rsp_err, 1'b1);
      chk ("inv2_psel", 32'(psel), 32'h0);
      tick();
      chk1("inv2_done_busy", busy, 1'b0);

      // 5: reset while in ACCESS drops the command
      pready = 3'b110;
      send(1'b1, 2'd0, 32'h20, 32'h5555_AAAA);
      tick();
      cmd_valid = 1'b0;
      tick();
      chk1("rs_access_penable", penable, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk ("rs_psel", 32'(psel), 32'h0);
      chk1("rs_penable", penable, 1'b0);
      chk1("rs_rsp_valid", rsp_valid, 1'b0);
      chk1("rs_cmd_ready", cmd_ready, 1'b1);
      pready = 3'b111;
      tick();
      tick();
      chk1("rs_dropped_rsp_valid", rsp_valid, 1'b0);
      chk1("rs_dropped_busy", busy, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
      // 6: slave never ready -> abort after 8 ACCESS cycles
      pready = 3'b000;
      prdata = {32'h0, 32'hCAFE_F00D, 32'h0};
      send(1'b0, 2'd1, 32'h30, 32'h0);
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 2; i <= 9; i++) begin
         chk1("to_wait_rsp_valid", rsp_valid, 1'b0);
         chk1("to_wait_penable", penable, 1'b1);
         tick();
      end
      chk1("to_rsp_valid", rsp_valid, 1'b1);
      chk1("to_rsp_err", rsp_err, 1'b1);
      chk1("to_rsp_timeout", rsp_timeout, 1'b1);
      chk ("to_rsp_rdata", rsp_rdata, 32'h0);
      chk ("to_psel", 32'(psel), 32'h0);
      chk1("to_penable", penable, 1'b0);
      tick();
      pready = 3'b111;
`else
      chk1("no_timeout_tied", rsp_timeout, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
